ll_window_accum: RTL and testbench

//  Downstream of ll_comp_unit: accumulates per-sample line-length terms |x[n]-x[n-1]|

---
 rtl/ll_window_accum_pkg.sv | 12 +
 rtl/ll_window_accum_if.sv | 19 +
 rtl/ll_win_buf.sv | 30 +++
 rtl/ll_window_accum.sv | 80 ++++++++
 tb/tb_ll_window_accum.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ll_window_accum_pkg.sv
// ll_window_accum_pkg: shared widths and defaults for the line-length feature chain
package ll_window_accum_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int LL_IN_W    = DATA_WIDTH + 1;
    localparam int LL_WIN_LEN = 256;
    localparam int LL_HOLD    = 4;

    // Worst-case window sum: WIN_LEN terms of IN_W-1 magnitude bits each.
    function automatic int sum_width(input int in_w, input int win_len);
        return in_w - 1 + $clog2(win_len);
    endfunction
endpackage

// File: rtl/ll_window_accum_if.sv
// ll_window_accum_if: sample stream in, windowed feature and detect flag out
interface ll_window_accum_if
    import ll_window_accum_pkg::*;
#(
    parameter int IN_W  = LL_IN_W,
    parameter int SUM_W = sum_width(LL_IN_W, LL_WIN_LEN)
);
    logic signed [IN_W-1:0] din;
    logic                   din_valid;
    logic                   flush;
    logic [SUM_W-1:0]       threshold;
    logic [SUM_W-1:0]       sum;
    logic                   sum_valid;
    logic                   upd;
    logic                   detect;

    modport master(output din, din_valid, flush, threshold, input sum, sum_valid, upd, detect);
    modport slave(input din, din_valid, flush, threshold, output sum, sum_valid, upd, detect);
endinterface

// File: rtl/ll_win_buf.sv
// ll_win_buf: circular sample buffer; read at the write pointer sees the entry being replaced
module ll_win_buf #(
    parameter int WIN_LEN = 256,
    parameter int W       = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic         i_clr,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata
);
    localparam int PW = $clog2(WIN_LEN);

    logic [W-1:0]  r_mem [WIN_LEN];
    logic [PW-1:0] r_wr_ptr;

    assign o_rdata = r_mem[r_wr_ptr];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[r_wr_ptr] <= i_wdata;
    end

    // WIN_LEN is a power of two, so the pointer wraps on its own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_wr_ptr <= '0;
        else if (i_clr) r_wr_ptr <= '0;
        else if (i_we) r_wr_ptr <= r_wr_ptr + 1'b1;
    end
endmodule

// File: rtl/ll_window_accum.sv
// ll_window_accum: sliding-window line-length sum with debounced over-threshold detect
module ll_window_accum
    import ll_window_accum_pkg::*;
#(
    parameter int IN_W    = LL_IN_W,
    parameter int WIN_LEN = LL_WIN_LEN,
    parameter int HOLD    = LL_HOLD
) (
    input logic              i_clk,
    input logic              i_rst_n,
    ll_window_accum_if.slave bus
);
    localparam int MAG_W = IN_W - 1;
    localparam int SUM_W = sum_width(IN_W, WIN_LEN);
    localparam int FW    = $clog2(WIN_LEN) + 1;
    localparam int RW    = $clog2(HOLD + 1);
    localparam logic [FW-1:0] FULL = FW'(WIN_LEN);
    localparam logic [RW-1:0] RMAX = RW'(HOLD);

    logic [FW-1:0]    r_fill;
    logic [RW-1:0]    r_run;
    logic [SUM_W-1:0] r_sum;
    logic             r_sum_valid;
    logic             r_upd;
    logic             r_detect;

    logic             w_acc;
    logic             w_full;
    logic             w_full_nx;
    logic             w_over;
    logic [MAG_W-1:0] w_term;
    logic [MAG_W-1:0] w_rd;
    logic [FW-1:0]    w_fill_nx;
    logic [SUM_W-1:0] w_sum_nx;
    logic [RW-1:0]    w_run_nx;

    ll_win_buf #(.WIN_LEN(WIN_LEN), .W(MAG_W)) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_acc),
        .i_clr   (bus.flush),
        .i_wdata (w_term),
        .o_rdata (w_rd)
    );

    assign w_acc     = bus.din_valid && !bus.flush;
    assign w_term    = bus.din[IN_W-1] ? '0 : bus.din[MAG_W-1:0];
    assign w_full    = r_fill == FULL;
    assign w_fill_nx = w_full ? r_fill : r_fill + 1'b1;
    assign w_full_nx = w_fill_nx == FULL;
    // Stale buffer entries are only subtracted once the window has been filled since restart.
    assign w_sum_nx  = r_sum + SUM_W'(w_term) - (w_full ? SUM_W'(w_rd) : '0);
    assign w_over    = w_full_nx && (w_sum_nx > bus.threshold);
    assign w_run_nx  = !w_over ? '0 : (r_run == RMAX) ? r_run : r_run + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill      <= '0;
            r_run       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_upd       <= 1'b0;
            r_detect    <= 1'b0;
        end else begin
            r_upd <= w_acc;
            if (bus.flush || w_acc) begin
                r_fill      <= bus.flush ? '0 : w_fill_nx;
                r_sum       <= bus.flush ? '0 : w_sum_nx;
                r_run       <= bus.flush ? '0 : w_run_nx;
                r_sum_valid <= !bus.flush && w_full_nx;
                r_detect    <= !bus.flush && (w_run_nx == RMAX);
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.sum_valid = r_sum_valid;
    assign bus.upd       = r_upd;
    assign bus.detect    = r_detect;
endmodule

// File: tb/tb_ll_window_accum.sv
// tb_ll_window_accum: directed table, reset/flush/max sequences and random stream vs. window model
module tb_ll_window_accum;
    localparam int IN_W    = 33;
    localparam int WIN_LEN = 4;
    localparam int HOLD    = 2;
    localparam int SUM_W   = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ll_window_accum_if #(.IN_W(IN_W), .SUM_W(SUM_W)) bus();

    ll_window_accum #(.IN_W(IN_W), .WIN_LEN(WIN_LEN), .HOLD(HOLD)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic signed [IN_W-1:0] din;
        logic                   valid;
        logic                   flush;
        logic [63:0]            sum;
        logic                   sv;
        logic                   upd;
        logic                   det;
    } vec_t;

    vec_t tbl[19];
    int total = 0;
    int bad = 0;

    longint unsigned hist[$];
    bit              ov[$];
    longint unsigned m_sum = 0;
    bit              m_sv = 0;
    bit              m_upd = 0;
    bit              m_det = 0;

    function automatic void model_clear();
        hist.delete();
        ov.delete();
        m_sum = 0;
        m_sv  = 0;
        m_upd = 0;
        m_det = 0;
    endfunction

    // Window = last WIN_LEN clamped accepted samples; detect = last HOLD updates all full and over.
    function automatic void model(input logic signed [IN_W-1:0] d, input logic v, input logic f,
                                  input logic [SUM_W-1:0] thr);
        longint unsigned s = 0;
        if (f) begin
            model_clear();
            return;
        end
        m_upd = v;
        if (!v) return;
        hist.push_back(d < 0 ? 64'd0 : 64'(d));
        if (hist.size() > WIN_LEN) void'(hist.pop_front());
        foreach (hist[i]) s += hist[i];
        m_sum = s;
        m_sv  = hist.size() == WIN_LEN;
        ov.push_back(m_sv && (s > 64'(thr)));
        if (ov.size() > HOLD) void'(ov.pop_front());
        m_det = ov.size() == HOLD;
        foreach (ov[i]) if (!ov[i]) m_det = 0;
    endfunction

    task automatic cmp(input string n, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", n, got, want, $time);
        end
    endtask

    task automatic chk_model(input string n);
        cmp({n, ".sum"}, 64'(bus.sum), m_sum);
        cmp({n, ".sum_valid"}, 64'(bus.sum_valid), 64'(m_sv));
        cmp({n, ".upd"}, 64'(bus.upd), 64'(m_upd));
        cmp({n, ".detect"}, 64'(bus.detect), 64'(m_det));
    endtask

    task automatic step(input logic signed [IN_W-1:0] d, input logic v, input logic f);
        bus.din       = d;
        bus.din_valid = v;
        bus.flush     = f;
        model(d, v, f, bus.threshold);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [IN_W-1:0] d;
        int neg;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.threshold = 34'd90;

        tbl[0]  = '{33'sd10,  1, 0,  10, 0, 1, 0};
        tbl[1]  = '{33'sd20,  1, 0,  30, 0, 1, 0};
        tbl[2]  = '{33'sd30,  1, 0,  60, 0, 1, 0};
        tbl[3]  = '{33'sd40,  1, 0, 100, 1, 1, 0};
        tbl[4]  = '{33'sd50,  1, 0, 140, 1, 1, 1};
        tbl[5]  = '{33'sd0,   1, 0, 120, 1, 1, 1};
        tbl[6]  = '{33'sd0,   1, 0,  90, 1, 1, 0};
        tbl[7]  = '{33'sd0,   0, 0,  90, 1, 0, 0};
        tbl[8]  = '{33'sd0,   1, 0,  50, 1, 1, 0};
        tbl[9]  = '{33'sd0,   1, 0,   0, 1, 1, 0};
        tbl[10] = '{-33'sd5,  1, 0,   0, 1, 1, 0};
        tbl[11] = '{33'sd0,   0, 0,   0, 1, 0, 0};
        tbl[12] = '{33'sd99,  1, 1,   0, 0, 0, 0};
        tbl[13] = '{33'sd3,   1, 0,   3, 0, 1, 0};
        tbl[14] = '{33'sd77,  1, 1,   0, 0, 0, 0};
        tbl[15] = '{33'sd7,   1, 0,   7, 0, 1, 0};
        tbl[16] = '{33'sd7,   1, 0,  14, 0, 1, 0};
        tbl[17] = '{33'sd7,   1, 0,  21, 0, 1, 0};
        tbl[18] = '{33'sd7,   1, 0,  28, 1, 1, 0};

        #1;
        chk_model("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].din, tbl[i].valid, tbl[i].flush);
            cmp($sformatf("vec%0d.sum", i), 64'(bus.sum), tbl[i].sum);
            cmp($sformatf("vec%0d.sum_valid", i), 64'(bus.sum_valid), 64'(tbl[i].sv));
            cmp($sformatf("vec%0d.upd", i), 64'(bus.upd), 64'(tbl[i].upd));
            cmp($sformatf("vec%0d.detect", i), 64'(bus.detect), 64'(tbl[i].det));
        end

        // Asynchronous reset mid-stream must clear outputs before the next clock edge.
        step(33'sd60, 1, 0);
        step(33'sd60, 1, 0);
        chk_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk_model("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < WIN_LEN; i++) begin
            step(33'sd1, 1, 0);
            chk_model("refill");
        end

        for (int i = 0; i < WIN_LEN + 8; i++) begin
            step(33'sh0_FFFF_FFFF, 1, 0);
            chk_model("max");
        end
        cmp("max_sum", 64'(bus.sum), 64'h3_FFFF_FFFC);

        bus.threshold = 34'd120;
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) bus.threshold = 34'($urandom_range(40, 220));
            case ($urandom_range(0, 9))
                0: begin
                    neg = $urandom_range(1, 1000);
                    d = -neg;
                end
                1: d = 33'sh0_FFFF_FFFF;
                default: d = 33'($urandom_range(0, 60));
            endcase
            step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            chk_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
